// File: rtl/digit_overlay_render_if.sv
// ----------------------------------------------------------------------------
// digit_overlay_render_if
//   Bundles the video-side signals of the digit overlay renderer: scan
//   position, incoming binary pixel, bounding box and recognised digit on
//   the way in, overlaid pixel and currently rendered digit on the way out.
//
//   Signals:
//     en         overlay enable / frame-sample enable
//     iEdge_Row  box rows    [9:0] top,  [19:10] bottom
//     iEdge_Col  box columns [9:0] left, [19:10] right
//     iRow/iCol  current scan position
//     iBWData    incoming binary pixel
//     iDigital   recognised digit code (0..9 valid, else blank)
//     oPixel     overlaid pixel, 2-cycle latency
//     oShown     digit currently rendered (4'hF = blank)
//
//   Modports:
//     master  video source side (drives inputs, observes outputs)
//     slave   renderer side
// ----------------------------------------------------------------------------
interface digit_overlay_render_if;
    logic        en;
    logic [19:0] iEdge_Row;
    logic [19:0] iEdge_Col;
    logic [9:0]  iRow;
    logic [9:0]  iCol;
    logic [9:0]  iBWData;
    logic [3:0]  iDigital;
    logic [9:0]  oPixel;
    logic [3:0]  oShown;

    modport master (
        output en, iEdge_Row, iEdge_Col, iRow, iCol, iBWData, iDigital,
        input  oPixel, oShown
    );

    modport slave (
        input  en, iEdge_Row, iEdge_Col, iRow, iCol, iBWData, iDigital,
        output oPixel, oShown
    );
endinterface

// File: rtl/digit_overlay_render.sv
// ----------------------------------------------------------------------------
// digit_overlay_render
//   Draws the recognised digit back onto the binary video stream as a
//   seven-segment glyph inside the digit's bounding box. The box and the
//   digit are sampled once per frame (scan position 0,0 with en high); a
//   stability filter only changes the rendered digit after the same code has
//   been seen for STABLE_FRAMES consecutive frame samples.
//
//   Parameters:
//     STROKE         segment thickness in pixels (1..15)
//     STABLE_FRAMES  identical frame samples needed to update (1..15)
//     ON_VALUE       pixel value driven on lit segment pixels
//
//   Ports:
//     clk  pixel clock
//     rst  asynchronous active-low reset
//     bus  video interface (slave side), see digit_overlay_render_if
//
//   Pipeline: stage 1 registers the 7 segment-region hits for the current
//   scan position plus the delayed pixel and enable; stage 2 masks the hits
//   with the glyph of the shown digit and muxes the output pixel.
// ----------------------------------------------------------------------------
module digit_overlay_render #(
    parameter int unsigned STROKE        = 4,
    parameter int unsigned STABLE_FRAMES = 3,
    parameter logic [9:0]  ON_VALUE      = 10'h3FF
) (
    input  logic                  clk,
    input  logic                  rst,
    digit_overlay_render_if.slave bus
);

    localparam logic [10:0] STROKE_W  = 11'(STROKE);
    localparam logic [10:0] STROKE_M1 = 11'(STROKE - 1);
    localparam logic [10:0] COORD_MAX = 11'h3FF;
    localparam logic [3:0]  CNT_MAX   = 4'(STABLE_FRAMES - 1);
    localparam logic [3:0]  BLANK     = 4'hF;

    typedef struct packed {
        logic [9:0] top;
        logic [9:0] bottom;
        logic [9:0] left;
        logic [9:0] right;
        logic [9:0] mid;
    } box_t;

    // base + off, clamped at the last coordinate instead of wrapping.
    function automatic logic [9:0] sat_add(input logic [9:0]  base,
                                           input logic [10:0] off);
        logic [10:0] sum;
        sum = {1'b0, base} + off;
        return (sum > COORD_MAX) ? 10'h3FF : sum[9:0];
    endfunction

    // base - STROKE + 1 (first coordinate of a stroke ending at base),
    // clamped at 0 instead of wrapping.
    function automatic logic [9:0] sat_inset(input logic [9:0] base);
        logic [10:0] end_excl;
        end_excl = {1'b0, base} + 11'd1;
        return (end_excl < STROKE_W) ? 10'h000 : 10'(end_excl - STROKE_W);
    endfunction

    // Lit segments per digit, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph_mask(input logic [3:0] code);
        case (code)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Frame-sample state: box, stability filter, shown digit
    // ------------------------------------------------------------------
    box_t        box_q, box_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  shown_q, shown_d;
    logic [10:0] mid_sum;
    logic        fs;

    assign fs = bus.en && (bus.iRow == 10'd0) && (bus.iCol == 10'd0);

    // NOTE: every variable gets its hold value first so that no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        box_d   = box_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        shown_d = shown_q;
        mid_sum = {1'b0, bus.iEdge_Row[9:0]} + {1'b0, bus.iEdge_Row[19:10]};

        if (fs) begin
            box_d.top    = bus.iEdge_Row[9:0];
            box_d.bottom = bus.iEdge_Row[19:10];
            box_d.left   = bus.iEdge_Col[9:0];
            box_d.right  = bus.iEdge_Col[19:10];
            box_d.mid    = 10'(mid_sum >> 1);

            if (bus.iDigital == cand_q) begin
                cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
            end else begin
                cand_d = bus.iDigital;
                cnt_d  = 4'd0;
            end

            // Uses the freshly updated candidate, so a single required
            // sample makes the shown digit follow iDigital directly.
            if (cnt_d == CNT_MAX) begin
                shown_d = cand_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: region tests against the box that is current this cycle
    // ------------------------------------------------------------------
    logic [9:0] a_bottom, d_top, g_bottom, bc_left, ef_right;
    logic       row_a, row_d, row_g, row_top_mid, row_mid_bot;
    logic       col_span, col_bc, col_ef;
    logic       degenerate;
    logic [6:0] hit_d, hit_q;
    logic [9:0] bw_q;
    logic       en_q;

    assign a_bottom = sat_add(box_q.top, STROKE_M1);
    assign d_top    = sat_inset(box_q.bottom);
    assign g_bottom = sat_add(box_q.mid, STROKE_M1);
    assign bc_left  = sat_inset(box_q.right);
    assign ef_right = sat_add(box_q.left, STROKE_M1);

    assign row_a       = (bus.iRow >= box_q.top)    && (bus.iRow <= a_bottom);
    assign row_d       = (bus.iRow >= d_top)        && (bus.iRow <= box_q.bottom);
    assign row_g       = (bus.iRow >= box_q.mid)    && (bus.iRow <= g_bottom);
    assign row_top_mid = (bus.iRow >= box_q.top)    && (bus.iRow <= box_q.mid);
    assign row_mid_bot = (bus.iRow >= box_q.mid)    && (bus.iRow <= box_q.bottom);
    assign col_span    = (bus.iCol >= box_q.left)   && (bus.iCol <= box_q.right);
    assign col_bc      = (bus.iCol >= bc_left)      && (bus.iCol <= box_q.right);
    assign col_ef      = (bus.iCol >= box_q.left)   && (bus.iCol <= ef_right);

    // An inverted or empty box blanks the whole glyph rather than drawing
    // partial strokes from wrapped ranges.
    assign degenerate = (box_q.bottom <= box_q.top) || (box_q.right <= box_q.left);

    assign hit_d = degenerate ? 7'b0000000 :
                   {row_g && col_span,        // g
                    col_ef && row_top_mid,    // f
                    col_ef && row_mid_bot,    // e
                    row_d && col_span,        // d
                    col_bc && row_mid_bot,    // c
                    col_bc && row_top_mid,    // b
                    row_a && col_span};       // a

    // ------------------------------------------------------------------
    // Stage 2: glyph mask and output mux
    // ------------------------------------------------------------------
    logic [9:0] pix_d, pix_q;

    assign pix_d = (en_q && |(hit_q & glyph_mask(shown_q))) ? ON_VALUE : bw_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            box_q   <= '0;
            cand_q  <= BLANK;
            cnt_q   <= 4'd0;
            shown_q <= BLANK;
            hit_q   <= '0;
            bw_q    <= '0;
            en_q    <= 1'b0;
            pix_q   <= '0;
        end else begin
            box_q   <= box_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            shown_q <= shown_d;
            hit_q   <= hit_d;
            bw_q    <= bus.iBWData;
            en_q    <= bus.en;
            pix_q   <= pix_d;
        end
    end

    assign bus.oPixel = pix_q;
    assign bus.oShown = shown_q;

endmodule

// File: tb/tb_digit_overlay_render.sv
`timescale 1ns/1ps
module tb_digit_overlay_render;

    localparam int         STROKE = 4;
    localparam int         SF     = 3;
    localparam logic [9:0] ON     = 10'h3FF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    digit_overlay_render_if bus ();

    digit_overlay_render #(
        .STROKE        (STROKE),
        .STABLE_FRAMES (SF),
        .ON_VALUE      (ON)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: box as last sampled, filter state, shown digit.
    int m_top, m_bot, m_left, m_right, m_mid;
    int m_cand, m_cnt, m_shown;

    // Values presented on the box/digit inputs by the next cycle() call.
    int cur_top, cur_bot, cur_left, cur_right, cur_dig;

    logic [9:0] exp_pipe [$];
    logic [9:0] pair_exp [$];
    logic [9:0] pair_obs [$];

    string glyph_str [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                              "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic int clamp(int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    function automatic bit inr(int v, int lo, int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Letters of every segment region containing (r,c) for the sampled box.
    function automatic string regions_hit(int r, int c);
        string s;
        s = "";
        if (m_bot <= m_top || m_right <= m_left) return s;
        if (inr(r, m_top, clamp(m_top + STROKE - 1)) && inr(c, m_left, m_right))     s = {s, "a"};
        if (inr(c, clamp(m_right - STROKE + 1), m_right) && inr(r, m_top, m_mid))    s = {s, "b"};
        if (inr(c, clamp(m_right - STROKE + 1), m_right) && inr(r, m_mid, m_bot))    s = {s, "c"};
        if (inr(r, clamp(m_bot - STROKE + 1), m_bot) && inr(c, m_left, m_right))     s = {s, "d"};
        if (inr(c, m_left, clamp(m_left + STROKE - 1)) && inr(r, m_mid, m_bot))      s = {s, "e"};
        if (inr(c, m_left, clamp(m_left + STROKE - 1)) && inr(r, m_top, m_mid))      s = {s, "f"};
        if (inr(r, m_mid, clamp(m_mid + STROKE - 1)) && inr(c, m_left, m_right))     s = {s, "g"};
        return s;
    endfunction

    function automatic bit glyph_lit(string hits, int shown);
        string g;
        if (shown > 9) return 1'b0;
        g = glyph_str[shown];
        for (int i = 0; i < hits.len(); i++)
            for (int j = 0; j < g.len(); j++)
                if (hits[i] == g[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_top = 0; m_bot = 0; m_left = 0; m_right = 0; m_mid = 0;
        m_cand = 15; m_cnt = 0; m_shown = 15;
        exp_pipe.delete();
    endtask

    // One pixel clock: collect the output of the pixel driven two cycles
    // ago, drive a new pixel and predict its output.
    task automatic cycle(input bit en_v, input int r, input int c, input logic [9:0] bw);
        string hits;
        bit    fs;
        @(negedge clk);
        if (exp_pipe.size() == 2) begin
            pair_exp.push_back(exp_pipe.pop_front());
            pair_obs.push_back(bus.oPixel);
        end
        bus.en        = en_v;
        bus.iRow      = 10'(r);
        bus.iCol      = 10'(c);
        bus.iBWData   = bw;
        bus.iDigital  = 4'(cur_dig);
        bus.iEdge_Row = {10'(cur_bot), 10'(cur_top)};
        bus.iEdge_Col = {10'(cur_right), 10'(cur_left)};
        hits = regions_hit(r, c);
        fs = en_v && (r == 0) && (c == 0);
        if (fs) begin
            m_top = cur_top; m_bot = cur_bot; m_left = cur_left; m_right = cur_right;
            m_mid = (cur_top + cur_bot) / 2;
            if (cur_dig == m_cand) m_cnt = imin(m_cnt + 1, SF - 1);
            else begin m_cand = cur_dig; m_cnt = 0; end
            if (m_cnt == SF - 1) m_shown = m_cand;
        end
        exp_pipe.push_back((en_v && glyph_lit(hits, m_shown)) ? ON : bw);
    endtask

    task automatic start_test();
        exp_pipe.delete();
        pair_exp.delete();
        pair_obs.delete();
    endtask

    task automatic drain();
        cycle(1'b0, 1, 1, 10'h000);
        cycle(1'b0, 1, 1, 10'h000);
    endtask

    task automatic set_box(input int t, input int b, input int l, input int r);
        cur_top = t; cur_bot = b; cur_left = l; cur_right = r;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #12;
        tests_run++;
        if (bus.oPixel !== 10'h000) begin
            tests_failed++;
            $display("FAIL reset_pixel: oPixel=%h expected 000", bus.oPixel);
        end
        tests_run++;
        if (bus.oShown !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_shown: oShown=%h expected f", bus.oShown);
        end
        @(negedge clk);
        rst = 1'b1;
        start_test();
        cycle(1'b1, 5, 5, 10'h155);
        drain();
        tests_run++;
        if (pair_obs.size() != 1 || pair_obs[0] !== 10'h155) begin
            tests_failed++;
            $display("FAIL reset_passthru: got %0d samples, oPixel=%h expected 155",
                     pair_obs.size(), (pair_obs.size() > 0) ? pair_obs[0] : 10'hx);
        end
    endtask

    task automatic test_stability();
        int seq  [8] = '{8, 8, 8, 7, 8, 5, 5, 5};
        int want [8] = '{15, 15, 8, 8, 8, 8, 8, 5};
        start_test();
        set_box(100, 200, 50, 110);
        for (int f = 0; f < 8; f++) begin
            cur_dig = seq[f];
            cycle(1'b1, 0, 0, 10'h000);
            @(posedge clk); #1;
            tests_run++;
            if (bus.oShown !== 4'(want[f])) begin
                tests_failed++;
                $display("FAIL stability_fs%0d: oShown=%h expected %h", f + 1, bus.oShown, 4'(want[f]));
            end
            for (int p = 0; p < 10; p++)
                cycle(1'b1, $urandom_range(95, 205), $urandom_range(45, 115), 10'($urandom));
        end
        drain();
        for (int i = 0; i < pair_obs.size(); i++) begin
            tests_run++;
            if (pair_obs[i] !== pair_exp[i]) begin
                tests_failed++;
                $display("FAIL stability_pix[%0d]: oPixel=%h expected %h", i, pair_obs[i], pair_exp[i]);
            end
        end
    endtask

    task automatic test_glyph1();
        int         rows [3] = '{150, 102, 150};
        int         cols [3] = '{108, 80, 52};
        logic [9:0] bws  [3] = '{10'h000, 10'h155, 10'h155};
        logic [9:0] want [3] = '{10'h3FF, 10'h155, 10'h155};
        set_box(100, 200, 50, 110);
        cur_dig = 1;
        for (int f = 0; f < 3; f++) cycle(1'b1, 0, 0, 10'h000);
        @(posedge clk); #1;
        tests_run++;
        if (bus.oShown !== 4'd1) begin
            tests_failed++;
            $display("FAIL glyph1_shown: oShown=%h expected 1", bus.oShown);
        end
        start_test();
        for (int i = 0; i < 3; i++) cycle(1'b1, rows[i], cols[i], bws[i]);
        drain();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (i >= pair_obs.size() || pair_obs[i] !== want[i]) begin
                tests_failed++;
                $display("FAIL glyph1_pix(%0d,%0d): oPixel=%h expected %h", rows[i], cols[i],
                         (i < pair_obs.size()) ? pair_obs[i] : 10'hx, want[i]);
            end
        end
    endtask

    task automatic test_glyph8();
        int         rows [6] = '{100, 103, 150, 200, 104, 149};
        int         cols [6] = '{50, 110, 80, 110, 80, 80};
        logic [9:0] want [6] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000, 10'h000};
        int         shw  [3] = '{1, 1, 8};
        set_box(100, 200, 50, 110);
        cur_dig = 8;
        for (int f = 0; f < 3; f++) begin
            cycle(1'b1, 0, 0, 10'h000);
            @(posedge clk); #1;
            tests_run++;
            if (bus.oShown !== 4'(shw[f])) begin
                tests_failed++;
                $display("FAIL glyph8_shown_fs%0d: oShown=%h expected %h", f + 1, bus.oShown, 4'(shw[f]));
            end
        end
        start_test();
        for (int i = 0; i < 6; i++) cycle(1'b1, rows[i], cols[i], 10'h000);
        drain();
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (i >= pair_obs.size() || pair_obs[i] !== want[i]) begin
                tests_failed++;
                $display("FAIL glyph8_pix(%0d,%0d): oPixel=%h expected %h", rows[i], cols[i],
                         (i < pair_obs.size()) ? pair_obs[i] : 10'hx, want[i]);
            end
        end
    endtask

    task automatic test_degenerate();
        logic [9:0] bw_log [$];
        logic [9:0] bw;
        set_box(200, 100, 50, 110);
        cur_dig = 8;
        cycle(1'b1, 0, 0, 10'h000);
        start_test();
        for (int p = 0; p < 150; p++) begin
            bw = 10'($urandom);
            bw_log.push_back(bw);
            cycle(1'b1, $urandom_range(90, 210), $urandom_range(40, 120), bw);
        end
        drain();
        for (int i = 0; i < bw_log.size(); i++) begin
            tests_run++;
            if (i >= pair_obs.size() || pair_obs[i] !== bw_log[i] || pair_exp[i] !== bw_log[i]) begin
                tests_failed++;
                $display("FAIL degenerate_pix[%0d]: oPixel=%h expected %h", i,
                         (i < pair_obs.size()) ? pair_obs[i] : 10'hx, bw_log[i]);
            end
        end
    endtask

    task automatic test_enable();
        logic [9:0] bw_log [$];
        logic [9:0] bw;
        set_box(100, 200, 50, 110);
        cur_dig = 8;
        cycle(1'b1, 0, 0, 10'h000);
        start_test();
        // Different box and digit on the inputs while disabled: neither
        // must be taken.
        set_box(500, 600, 500, 600);
        cur_dig = 3;
        for (int p = 0; p < 80; p++) begin
            bw = 10'($urandom);
            bw_log.push_back(bw);
            if (p == 0) cycle(1'b0, 0, 0, bw);
            else        cycle(1'b0, $urandom_range(100, 200), $urandom_range(50, 110), bw);
        end
        cycle(1'b1, 150, 80, 10'h000);
        drain();
        for (int i = 0; i < bw_log.size(); i++) begin
            tests_run++;
            if (i >= pair_obs.size() || pair_obs[i] !== bw_log[i]) begin
                tests_failed++;
                $display("FAIL enable_pix[%0d]: oPixel=%h expected %h", i,
                         (i < pair_obs.size()) ? pair_obs[i] : 10'hx, bw_log[i]);
            end
        end
        tests_run++;
        if (pair_obs.size() != 81 || pair_obs[80] !== 10'h3FF) begin
            tests_failed++;
            $display("FAIL enable_box_held: oPixel=%h expected 3ff",
                     (pair_obs.size() > 80) ? pair_obs[80] : 10'hx);
        end
        tests_run++;
        if (bus.oShown !== 4'd8) begin
            tests_failed++;
            $display("FAIL enable_shown_held: oShown=%h expected 8", bus.oShown);
        end
    endtask

    task automatic test_latency();
        logic [9:0] bw_log [$];
        logic [9:0] bw;
        start_test();
        for (int i = 0; i < 12; i++) begin
            bw = (i == 4) ? 10'h3FF : 10'h000;
            bw_log.push_back(bw);
            cycle(1'b1, 5, 5 + i, bw);
        end
        drain();
        for (int i = 0; i < 12; i++) begin
            tests_run++;
            if (i >= pair_obs.size() || pair_obs[i] !== bw_log[i]) begin
                tests_failed++;
                $display("FAIL latency_pix[%0d]: oPixel=%h expected %h", i,
                         (i < pair_obs.size()) ? pair_obs[i] : 10'hx, bw_log[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int         ra [7] = '{0, 1, 1019, 1021, 1022, 1023, 1};
        int         ca [7] = '{500, 500, 500, 500, 500, 500, 1021};
        logic [9:0] wa [7] = '{10'h000, 10'h000, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000};
        int         rb [5] = '{12, 12, 9, 21, 20};
        int         cb [5] = '{0, 1, 1, 1, 2};
        logic [9:0] wb [5] = '{10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h3FF};
        // Box hugging the bottom edge: stroke ends clamp at row 1023.
        set_box(1022, 1023, 0, 1023);
        cur_dig = 8;
        for (int f = 0; f < 3; f++) cycle(1'b1, 0, 0, 10'h000);
        start_test();
        for (int i = 0; i < 7; i++) cycle(1'b1, ra[i], ca[i], 10'h000);
        drain();
        for (int i = 0; i < 7; i++) begin
            tests_run++;
            if (i >= pair_obs.size() || pair_obs[i] !== wa[i]) begin
                tests_failed++;
                $display("FAIL sat_bottom(%0d,%0d): oPixel=%h expected %h", ra[i], ca[i],
                         (i < pair_obs.size()) ? pair_obs[i] : 10'hx, wa[i]);
            end
        end
        // Box narrower than the stroke at column 0: right stroke clamps at 0.
        set_box(10, 20, 0, 2);
        cur_dig = 1;
        for (int f = 0; f < 3; f++) cycle(1'b1, 0, 0, 10'h000);
        start_test();
        for (int i = 0; i < 5; i++) cycle(1'b1, rb[i], cb[i], 10'h000);
        drain();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (i >= pair_obs.size() || pair_obs[i] !== wb[i]) begin
                tests_failed++;
                $display("FAIL sat_left(%0d,%0d): oPixel=%h expected %h", rb[i], cb[i],
                         (i < pair_obs.size()) ? pair_obs[i] : 10'hx, wb[i]);
            end
        end
    endtask

    task automatic test_random();
        int t, b, l, r, lo_r, hi_r, lo_c, hi_c;
        start_test();
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 9) < 8) begin
                t = $urandom_range(0, 900);
                b = clamp(t + $urandom_range(STROKE, 120));
                l = $urandom_range(0, 900);
                r = clamp(l + $urandom_range(1, 120));
            end else begin
                t = $urandom_range(0, 1023);
                b = $urandom_range(0, 1023);
                l = $urandom_range(0, 1023);
                r = $urandom_range(0, 1023);
            end
            set_box(t, b, l, r);
            if ($urandom_range(0, 9) < 4) cur_dig = $urandom_range(0, 15);
            cycle($urandom_range(0, 9) != 0, 0, 0, 10'($urandom));
            @(posedge clk); #1;
            tests_run++;
            if (bus.oShown !== 4'(m_shown)) begin
                tests_failed++;
                $display("FAIL random_shown_f%0d: oShown=%h expected %h", f, bus.oShown, 4'(m_shown));
            end
            lo_r = clamp(imin(t, b) - 3); hi_r = clamp(imax(t, b) + 3);
            lo_c = clamp(imin(l, r) - 3); hi_c = clamp(imax(l, r) + 3);
            for (int p = 0; p < 60; p++)
                cycle($urandom_range(0, 19) != 0, $urandom_range(lo_r, hi_r),
                      $urandom_range(lo_c, hi_c), 10'($urandom));
        end
        drain();
        for (int i = 0; i < pair_obs.size(); i++) begin
            tests_run++;
            if (pair_obs[i] !== pair_exp[i]) begin
                tests_failed++;
                $display("FAIL random_pix[%0d]: oPixel=%h expected %h", i, pair_obs[i], pair_exp[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int shw [3] = '{15, 15, 8};
        set_box(100, 200, 50, 110);
        cur_dig = 8;
        for (int f = 0; f < 3; f++) cycle(1'b1, 0, 0, 10'h000);
        for (int p = 0; p < 4; p++) cycle(1'b1, 150, 80, 10'h000);
        @(posedge clk); #2;
        tests_run++;
        if (bus.oPixel !== 10'h3FF || bus.oShown !== 4'd8) begin
            tests_failed++;
            $display("FAIL midreset_before: oPixel=%h oShown=%h expected 3ff/8", bus.oPixel, bus.oShown);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.oPixel !== 10'h000 || bus.oShown !== 4'hF) begin
            tests_failed++;
            $display("FAIL midreset_async: oPixel=%h oShown=%h expected 000/f", bus.oPixel, bus.oShown);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        start_test();
        for (int f = 0; f < 3; f++) begin
            cycle(1'b1, 0, 0, 10'h000);
            @(posedge clk); #1;
            tests_run++;
            if (bus.oShown !== 4'(shw[f])) begin
                tests_failed++;
                $display("FAIL midreset_refilter_fs%0d: oShown=%h expected %h", f + 1, bus.oShown, 4'(shw[f]));
            end
        end
        for (int p = 0; p < 20; p++)
            cycle(1'b1, $urandom_range(95, 205), $urandom_range(45, 115), 10'($urandom));
        drain();
        for (int i = 0; i < pair_obs.size(); i++) begin
            tests_run++;
            if (pair_obs[i] !== pair_exp[i]) begin
                tests_failed++;
                $display("FAIL midreset_pix[%0d]: oPixel=%h expected %h", i, pair_obs[i], pair_exp[i]);
            end
        end
    endtask

    initial begin
        bus.en        = 1'b0;
        bus.iRow      = 10'd5;
        bus.iCol      = 10'd5;
        bus.iBWData   = 10'h000;
        bus.iDigital  = 4'hF;
        bus.iEdge_Row = '0;
        bus.iEdge_Col = '0;
        set_box(0, 0, 0, 0);
        cur_dig = 15;
        model_reset();

        test_reset();
        test_stability();
        test_glyph1();
        test_glyph8();
        test_degenerate();
        test_enable();
        test_latency();
        test_saturation();
        test_random();
        test_reset_midframe();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/digit_overlay_render.md
# digit_overlay_render

Renders the recognised digit back onto the video stream as a seven-segment glyph drawn inside the digit's bounding box. It is the inverse of the recognition path: that path turns pixels into a digit code, and this block turns a digit code into pixels. It sits after digital_recognition in the DSP chain, between the binary-image stream and the TV output mux. A frame-stability filter latches a new glyph only after the code has held for a programmable number of frames, which prevents flicker.

## Interface
- STROKE, 4: segment stroke thickness in pixels (1..15)
- STABLE_FRAMES, 3: consecutive identical frame samples needed before the displayed digit updates (1..15)
- ON_VALUE, 10'h3FF: pixel value driven on lit segment pixels
- clk  input  1  pixel clock; reset rst, asynchronous, active-low; clock clk
- rst  input  1  asynchronous active-low reset
- en  input  1  overlay enable and frame-sample enable
- iEdge_Row  input  20  box rows: [9:0] top, [19:10] bottom
- iEdge_Col  input  20  box columns: [9:0] left, [19:10] right
- iRow  input  10  current scan row
- iCol  input  10  current scan column
- iBWData  input  10  incoming binary pixel (10'h000 or 10'h3FF)
- iDigital  input  4  recognised digit code; 0..9 valid, any other value means blank
- oPixel  output  10  overlaid pixel, 2-cycle latency
- oShown  output  4  digit currently rendered (4'hF = blank)

## Operation
- **Frame start (FS):** the cycle where iRow==0 && iCol==0 && en==1.
- **Actions at FS, all in one cycle:**
  - Latch the box registers top/bottom/left/right from iEdge_Row and iEdge_Col.
  - Compute mid = (top+bottom)>>1 using an 11-bit sum, truncated to 10 bits.
- **Stability filter, evaluated at FS:**
  - If iDigital==cand: cnt <= min(cnt+1, STABLE_FRAMES-1).
  - Otherwise: cand <= iDigital and cnt <= 0.
  - When the updated cnt equals STABLE_FRAMES-1, shown <= cand (the new cand when STABLE_FRAMES==1).
  - With STABLE_FRAMES==1, shown follows iDigital at every FS.
- **Segment regions.** All bounds are inclusive. Subtractions saturate at 0 and additions saturate at 10'h3FF.
  - a: rows top..top+STROKE-1; cols left..right.
  - b: cols right-STROKE+1..right; rows top..mid.
  - c: cols right-STROKE+1..right; rows mid..bottom.
  - d: rows bottom-STROKE+1..bottom; cols left..right.
  - e: cols left..left+STROKE-1; rows mid..bottom.
  - f: cols left..left+STROKE-1; rows top..mid.
  - g: rows mid..mid+STROKE-1; cols left..right.
- **Glyph map (shown → lit segments):**
  - 0: abcdef
  - 1: bc
  - 2: abdeg
  - 3: abcdg
  - 4: bcfg
  - 5: acdfg
  - 6: acdefg
  - 7: abc
  - 8: abcdefg
  - 9: abcdfg
  - 10..15: none
- **Degenerate box:** if bottom<=top or right<=left, no segments are lit for the whole frame.
- **Pixel output:**
  - lit = en && (pixel lies in any enabled segment region).
  - oPixel = lit ? ON_VALUE : iBWData.
- **en low:**
  - The pipeline keeps running and oPixel passes iBWData through with 2-cycle latency.
  - No FS occurs, so the box, cand, cnt and shown hold their values.
- **Reset values:**
  - oPixel = 0, oShown = 4'hF, cand = 4'hF, cnt = 0.
  - Box registers = 0, which is degenerate, so nothing is lit.

## Timing
- **Stage 1 (registered):**
  - All region comparisons for (iRow, iCol) against the latched box, using the box value that is current in this cycle.
  - Segment-hit vector (7 bits).
  - iBWData delayed one cycle.
  - en delayed one cycle.
- **Stage 2 (registered):** hit vector ANDed with the glyph mask of shown, reduced and ANDed with the delayed en, then the oPixel mux.
- **Latency:** 2 cycles from input pixel to oPixel; throughput is one pixel per clock.
- **Box and shown update:**
  - Both update at the FS clock edge.
  - The pixel presented in the FS cycle is compared against the old box.
  - That pixel goes through the glyph mask in the next cycle, by which time it uses the new shown.
  - Every pixel from (0,1) onward uses the new box and the new shown.
- **oShown** changes at the FS edge on which the filter condition is met.
- **Async reset mid-frame:** all state clears immediately. The first FS after rst deasserts restarts the filter (cand 4'hF, cnt 0).
- **Simultaneous events:** if iDigital changes in the FS cycle, the FS-cycle value is the one sampled.

## Test plan
- **Reset:** assert rst low mid-stream → oPixel=0 and oShown=4'hF immediately; after release, with box 0 and iBWData=10'h155, oPixel=10'h155 two cycles later.
- **Stability:** STABLE_FRAMES=3, iDigital=8 at three consecutive FS → oShown stays 4'hF after FS1 and FS2, becomes 8 at FS3; sending 7 at FS4 then 8 at FS5 → oShown stays 8, cnt is reset to 0.
- **Glyph 1:** box top=100, bottom=200, left=50, right=110, STROKE=4, shown=1 → pixel (150,108)=10'h3FF, pixel (102,80) passes through iBWData, pixel (150,52) passes through.
- **Glyph 8 boundaries:** same box → (100,50), (103,110), (150,80) (seg g: mid=150), (200,110) are lit; (104,80) and (149,80) are not.
- **Degenerate and enable:**
  - top=200, bottom=100, shown=8 → no pixel lit all frame.
  - en=0 for a full frame → oPixel equals iBWData delayed 2 cycles, and oShown is unchanged.
- **Latency and saturation:**
  - Single-pixel iBWData pulse → appears on oPixel exactly 2 cycles later.
  - Box top=1022, bottom=1023 → seg a/d bounds saturate, with no wrap to row 0.
